// File: rtl/cam_pkg.sv
// Shared constants and types for the content-addressable memory.
package cam_pkg;

    localparam int unsigned CAM_DATA  = 32;
    localparam int unsigned CAM_DEPTH = 32;
    localparam int unsigned CAM_WRITE = 4;
    localparam int unsigned CAM_READ  = 4;
    localparam int unsigned CAM_ADDR  = $clog2(CAM_DEPTH);

    // Write/search enables are active-low.
    localparam logic Enable_  = 1'b0;
    localparam logic Disable_ = 1'b1;

    typedef logic [CAM_DATA-1:0] entry_t;
    typedef logic [CAM_ADDR-1:0] addr_t;

endpackage

// File: rtl/cam_match_enc.sv
// Reduces one search port's hit vector to match, multi-hit and the lowest hit index.
module cam_match_enc
    import cam_pkg::*;
#(
    parameter int unsigned DEPTH = CAM_DEPTH,
    parameter int unsigned ADDR  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] hit,
    output logic             match,
    output logic             multi,
    output logic [ADDR-1:0]  addr
);

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    always_comb begin
        match = |hit;
        multi = |(hit & (hit - DEPTH'(1)));
        addr  = '0;
        for (int unsigned i = DEPTH; i > 0; i--) begin
            if (hit[i-1]) begin
                addr = ADDR'(i - 1);
            end
        end
    end

endmodule

// File: rtl/cam.sv
// Multi-port CAM: masked writes with highest-port priority, combinational masked search.
module cam
    import cam_pkg::*;
#(
    parameter int unsigned DATA  = CAM_DATA,
    parameter int unsigned DEPTH = CAM_DEPTH,
    parameter int unsigned WRITE = CAM_WRITE,
    parameter int unsigned READ  = CAM_READ,
    parameter int unsigned ADDR  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WRITE-1:0]      we_,
    input  logic [DATA*WRITE-1:0] wm,
    input  logic [DATA*WRITE-1:0] wd,
    input  logic [ADDR*WRITE-1:0] waddr,
    input  logic [READ-1:0]       re_,
    input  logic [DATA*READ-1:0]  rm,
    input  logic [DATA*READ-1:0]  rd,
    output logic [READ-1:0]       match,
    output logic [READ-1:0]       multi,
    output logic [ADDR*READ-1:0]  raddr
);

    logic [DATA-1:0]  mem       [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [DATA-1:0]  mem_nxt   [DEPTH];
    logic [DEPTH-1:0] valid_nxt;
    logic [DEPTH-1:0] hit       [READ];

    // Per-entry write merge; ascending port scan lets the highest-numbered port win,
    // and an address beyond DEPTH never equals any entry index so it is dropped.
    always_comb begin
        mem_nxt   = mem;
        valid_nxt = valid;
        for (int unsigned e = 0; e < DEPTH; e++) begin
            for (int unsigned p = 0; p < WRITE; p++) begin
                if (we_[p] == Enable_ && waddr[p*ADDR +: ADDR] == ADDR'(e)) begin
                    mem_nxt[e]   = (mem[e] & wm[p*DATA +: DATA]) |
                                   (wd[p*DATA +: DATA] & ~wm[p*DATA +: DATA]);
                    valid_nxt[e] = 1'b1;
                end
            end
        end
    end

    // Storage update; reset wipes data and valid flags asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                mem[e] <= '0;
            end
            valid <= '0;
        end else begin
            mem   <= mem_nxt;
            valid <= valid_nxt;
        end
    end

    // Per-port, per-entry masked comparators on pre-edge contents.
    always_comb begin
        for (int unsigned q = 0; q < READ; q++) begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                hit[q][e] = (re_[q] == Enable_) && valid[e] &&
                            (((mem[e] ^ rd[q*DATA +: DATA]) & ~rm[q*DATA +: DATA]) == '0);
            end
        end
    end

    for (genvar q = 0; q < READ; q++) begin : g_enc
        cam_match_enc #(
            .DEPTH (DEPTH),
            .ADDR  (ADDR)
        ) u_enc (
            .hit   (hit[q]),
            .match (match[q]),
            .multi (multi[q]),
            .addr  (raddr[q*ADDR +: ADDR])
        );
    end

endmodule

// File: tb/tb_cam.sv
// Self-checking bench for cam: directed literal checks plus randomized traffic vs. a behavioural model.
module tb_cam;
    import cam_pkg::*;

    localparam int unsigned D  = 32;
    localparam int unsigned N  = 32;
    localparam int unsigned W  = 4;
    localparam int unsigned R  = 4;
    localparam int unsigned A  = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic [W-1:0]     we_;
    logic [D*W-1:0]   wm;
    logic [D*W-1:0]   wd;
    logic [A*W-1:0]   waddr;
    logic [R-1:0]     re_;
    logic [D*R-1:0]   rm;
    logic [D*R-1:0]   rd;
    logic [R-1:0]     match;
    logic [R-1:0]     multi;
    logic [A*R-1:0]   raddr;

    int n_checks = 0;
    int n_fail   = 0;

    entry_t m_data  [N];
    logic   m_valid [N];

    cam #(
        .DATA  (D),
        .DEPTH (N),
        .WRITE (W),
        .READ  (R)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .we_   (we_),
        .wm    (wm),
        .wd    (wd),
        .waddr (waddr),
        .re_   (re_),
        .rm    (rm),
        .rd    (rd),
        .match (match),
        .multi (multi),
        .raddr (raddr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model storage: last enabled port in ascending order wins; reset clears at once.
    always @(posedge clk or posedge reset) begin : model_upd
        entry_t nd [N];
        logic   nv [N];
        int unsigned a;
        if (reset) begin
            for (int e = 0; e < N; e++) begin
                m_data[e]  = '0;
                m_valid[e] = 1'b0;
            end
        end else begin
            nd = m_data;
            nv = m_valid;
            for (int p = 0; p < W; p++) begin
                if (!we_[p]) begin
                    a = waddr[p*A +: A];
                    if (a < N) begin
                        nd[a] = (m_data[a] & wm[p*D +: D]) | (wd[p*D +: D] & ~wm[p*D +: D]);
                        nv[a] = 1'b1;
                    end
                end
            end
            m_data  = nd;
            m_valid = nv;
        end
    end

    // Every cycle, away from the active edge, compare all search ports with the model.
    always @(negedge clk) begin : compare
        int cnt;
        int low;
        entry_t key;
        entry_t msk;
        for (int q = 0; q < R; q++) begin
            cnt = 0;
            low = 0;
            key = rd[q*D +: D];
            msk = rm[q*D +: D];
            if (!re_[q]) begin
                for (int e = N - 1; e >= 0; e--) begin
                    if (m_valid[e] && ((m_data[e] ^ key) & ~msk) == 0) begin
                        cnt++;
                        low = e;
                    end
                end
            end
            check($sformatf("model match[%0d]", q), 32'(match[q]), 32'(cnt > 0));
            check($sformatf("model multi[%0d]", q), 32'(multi[q]), 32'(cnt > 1));
            check($sformatf("model raddr[%0d]", q), 32'(raddr[q*A +: A]), 32'(low));
        end
    end

    task automatic idle();
        we_   = '1;
        re_   = '1;
        wm    = '0;
        wd    = '0;
        waddr = '0;
        rm    = '0;
        rd    = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state: all-zero key with no valid entries must miss.
        re_ = '0;
        #1;
        check("rst match", 32'(match), 32'h0);
        check("rst multi", 32'(multi), 32'h0);
        check("rst raddr", 32'(raddr), 32'h0);

        // Four writes in one cycle; searches disabled.
        step(); idle();
        for (int p = 0; p < W; p++) begin
            we_[p]          = 1'b0;
            wd[p*D +: D]    = 32'h100 << p;
            waddr[p*A +: A] = 5'(2 * p);
        end
        #1;
        check("disabled match", 32'(match), 32'h0);

        step(); idle();
        re_ = '0;
        for (int q = 0; q < R; q++) rd[q*D +: D] = 32'h100 << q;
        #1;
        check("t1 match", 32'(match), 32'hF);
        check("t1 multi", 32'(multi), 32'h0);
        check("t1 raddr", 32'(raddr), {5'd6, 5'd4, 5'd2, 5'd0});
        for (int q = 0; q < R; q++) rd[q*D +: D] = 32'h100 << (q + 2);
        #1;
        check("t2 match", 32'(match), 32'h3);
        check("t2 raddr", 32'(raddr), {5'd0, 5'd0, 5'd6, 5'd4});

        // Full ignore mask hits every valid entry.
        step(); idle();
        re_[0] = 1'b0;
        rm[0 +: D] = '1;
        #1;
        check("allmask match", 32'(match[0]), 32'h1);
        check("allmask multi", 32'(multi[0]), 32'h1);
        check("allmask raddr", 32'(raddr[0 +: A]), 32'h0);

        // Masked write over 0x100 at address 0.
        step(); idle();
        we_[0] = 1'b0;
        wd[0 +: D] = 32'hFFFF_FFFF;
        wm[0 +: D] = 32'hFFFF_00FF;
        step(); idle();
        re_[1:0] = 2'b00;
        rd[0 +: D] = 32'h0000_FF00;
        rd[D +: D] = 32'h0000_0100;
        #1;
        check("mwr match", 32'(match[0]), 32'h1);
        check("mwr multi", 32'(multi[0]), 32'h0);
        check("mwr raddr", 32'(raddr[0 +: A]), 32'h0);
        check("mwr old gone", 32'(match[1]), 32'h0);

        // Write conflict on address 5; search during the write still sees old contents.
        step(); idle();
        we_[0] = 1'b0; wd[0 +: D] = 32'hA; waddr[0 +: A] = 5'd5;
        we_[3] = 1'b0; wd[3*D +: D] = 32'hB; waddr[3*A +: A] = 5'd5;
        re_[0] = 1'b0; rd[0 +: D] = 32'hB;
        #1;
        check("rdw match", 32'(match[0]), 32'h0);
        step(); idle();
        re_[1:0] = 2'b00;
        rd[0 +: D] = 32'hA;
        rd[D +: D] = 32'hB;
        #1;
        check("conflict loser", 32'(match[0]), 32'h0);
        check("conflict winner", 32'(match[1]), 32'h1);
        check("conflict raddr", 32'(raddr[A +: A]), 32'd5);
        #1;
        reset = 1'b1;
        #1;
        check("in-reset match", 32'(match), 32'h0);
        reset = 1'b0;
        step(); idle();
        re_[1] = 1'b0;
        rd[D +: D] = 32'hB;
        #1;
        check("post-reset match", 32'(match[1]), 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(); idle();
            for (int p = 0; p < W; p++) begin
                we_[p]          = 1'($urandom_range(0, 1));
                waddr[p*A +: A] = 5'($urandom_range(0, N - 1));
                wd[p*D +: D]    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7));
                wm[p*D +: D]    = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
            end
            for (int q = 0; q < R; q++) begin
                entry_t msk;
                case ($urandom_range(0, 5))
                    0:       msk = '1;
                    1, 2:    msk = $urandom;
                    default: msk = '0;
                endcase
                re_[q]       = ($urandom_range(0, 4) == 0);
                rm[q*D +: D] = msk;
                rd[q*D +: D] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) :
                               (m_data[$urandom_range(0, N - 1)] ^ ($urandom & msk));
            end
            if (i == 300) begin
                #1;
                reset = 1'b1;
                #1;
                reset = 1'b0;
            end
        end

        step(); idle();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
